// File: rtl/adc_scan_ctrl.sv
// ============================================================================
// adc_scan_ctrl : multi-channel TLC2543 scan sequencer with per-channel averaging
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module adc_scan_ctrl #(
  parameter int N_CH     = 8,
  parameter int AVG_LOG2 = 2,
  parameter int GAP      = 20,
  parameter int TIMEOUT  = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  output logic        adc_start,
  output logic [7:0]  adc_din,
  input  logic [11:0] adc_dout,
  input  logic        adc_done,
  output logic [11:0] ch_data,
  output logic [3:0]  ch_idx,
  output logic        ch_valid,
  output logic        scan_done,
  output logic        busy,
  output logic        err
);

  localparam int         N_FR    = N_CH * (1 << AVG_LOG2) + 1;
  localparam int         ACC_W   = 12 + AVG_LOG2;
  localparam int         TO_W    = $clog2(TIMEOUT + 2);
  localparam int         GAP_W   = $clog2(GAP + 1);
  localparam logic [7:0] SMASK   = 8'((1 << AVG_LOG2) - 1);
  localparam logic [7:0] LAST_FR = 8'(N_FR - 1);
  localparam logic [7:0] END_FR  = 8'(N_FR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         frame_q, frame_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         din_q, din_d;
  logic [11:0]        data_q, data_d;
  logic [3:0]         idx_q, idx_d;
  logic               err_q, err_d;
  logic               sdone_q, sdone_d;

  logic [7:0]         w_fm1;
  logic [7:0]         w_samp;
  logic [ACC_W-1:0]   w_acc_sum;

  // Last frame of the scan addresses the self-test input so the final real sample is flushed out.
  function automatic logic [7:0] cmd_byte(input logic [7:0] f);
    if (f == LAST_FR) return {4'hB, 2'b00, 1'b0, 1'b0};
    return {4'(f >> AVG_LOG2), 2'b00, 1'b0, 1'b0};
  endfunction

  // The result of the current frame belongs to the previous frame's channel.
  assign w_fm1     = frame_q - 8'd1;
  assign w_samp    = w_fm1 & SMASK;
  assign w_acc_sum = (w_samp == 8'd0) ? ACC_W'(adc_dout) : acc_q + ACC_W'(adc_dout);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    to_d    = '0;
    gap_d   = '0;
    acc_d   = acc_q;
    din_d   = din_q;
    data_d  = data_q;
    idx_d   = idx_q;
    err_d   = err_q;
    sdone_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The scan_done cycle is not a start opportunity, giving a 2-cycle turnaround.
        if (scan_en && !sdone_q) begin
          state_d = S_ISSUE;
          frame_d = 8'd0;
          err_d   = 1'b0;
          din_d   = cmd_byte(8'd0);
        end
      end
      S_ISSUE: begin
        to_d    = TO_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (adc_done) begin
          frame_d = frame_q + 8'd1;
          state_d = S_GAP;
          if (frame_q != 8'd0) begin
            acc_d = w_acc_sum;
            if (w_samp == SMASK) begin
              data_d  = w_acc_sum[11+AVG_LOG2:AVG_LOG2];
              idx_d   = 4'(w_fm1 >> AVG_LOG2);
              state_d = S_EMIT;
            end
          end
        end else if (to_q == TO_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_EMIT: state_d = S_GAP;
      S_GAP: begin
        if (gap_q == GAP_W'(GAP - 1)) begin
          if (frame_q == END_FR) begin
            sdone_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ISSUE;
            din_d   = cmd_byte(frame_q);
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      to_q    <= '0;
      gap_q   <= '0;
      acc_q   <= '0;
      din_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      sdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      acc_q   <= acc_d;
      din_q   <= din_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      sdone_q <= sdone_d;
    end
  end

  assign adc_start = (state_q == S_ISSUE);
  assign ch_valid  = (state_q == S_EMIT);
  assign busy      = (state_q != S_IDLE);
  assign adc_din   = din_q;
  assign ch_data   = data_q;
  assign ch_idx    = idx_q;
  assign err       = err_q;
  assign scan_done = sdone_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
// ============================================================================
// tb_adc_scan_ctrl : directed bench for adc_scan_ctrl with a TLC2543 driver model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_adc_scan_ctrl;

  localparam int LAT  = 4;
  localparam int GAP0 = 3;
  localparam int TO0  = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        scan_en   [3];
  logic        adc_done  [3];
  logic [11:0] adc_dout  [3];
  logic        adc_start [3];
  logic [7:0]  adc_din   [3];
  logic [11:0] ch_data   [3];
  logic [3:0]  ch_idx    [3];
  logic        ch_valid  [3];
  logic        scan_done [3];
  logic        busy      [3];
  logic        err       [3];

  adc_scan_ctrl #(.N_CH(2), .AVG_LOG2(0), .GAP(GAP0), .TIMEOUT(TO0)) u0 (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en[0]), .adc_start(adc_start[0]),
    .adc_din(adc_din[0]), .adc_dout(adc_dout[0]), .adc_done(adc_done[0]),
    .ch_data(ch_data[0]), .ch_idx(ch_idx[0]), .ch_valid(ch_valid[0]),
    .scan_done(scan_done[0]), .busy(busy[0]), .err(err[0]));

  adc_scan_ctrl #(.N_CH(1), .AVG_LOG2(2), .GAP(2), .TIMEOUT(TO0)) u1 (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en[1]), .adc_start(adc_start[1]),
    .adc_din(adc_din[1]), .adc_dout(adc_dout[1]), .adc_done(adc_done[1]),
    .ch_data(ch_data[1]), .ch_idx(ch_idx[1]), .ch_valid(ch_valid[1]),
    .scan_done(scan_done[1]), .busy(busy[1]), .err(err[1]));

  adc_scan_ctrl #(.N_CH(1), .AVG_LOG2(4), .GAP(1), .TIMEOUT(TO0)) u2 (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en[2]), .adc_start(adc_start[2]),
    .adc_din(adc_din[2]), .adc_dout(adc_dout[2]), .adc_done(adc_done[2]),
    .ch_data(ch_data[2]), .ch_idx(ch_idx[2]), .ch_valid(ch_valid[2]),
    .scan_done(scan_done[2]), .busy(busy[2]), .err(err[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver model: answers each adc_start with adc_done LAT cycles later.
  logic        drv_mute  [3];
  int          drv_frame [3];
  logic [11:0] drv_val   [3][64];

  for (genvar g = 0; g < 3; g++) begin : g_drv
    initial begin
      adc_done[g] = 1'b0;
      adc_dout[g] = '0;
      forever begin
        @(posedge clk); #1;
        if (adc_start[g] === 1'b1 && !drv_mute[g]) begin
          adc_dout[g]  = drv_val[g][drv_frame[g] % 64];
          drv_frame[g] = drv_frame[g] + 1;
          repeat (LAT) begin @(posedge clk); #1; end
          adc_done[g] = 1'b1;
          @(posedge clk); #1;
          adc_done[g] = 1'b0;
        end
      end
    end
  end

  // Event recorder
  int          st_n [3];
  int          st_cyc [3][64];
  logic [7:0]  st_din [3][64];
  int          dn_n [3];
  logic [7:0]  dn_din [3][64];
  int          v_n [3];
  int          v_cyc [3][16];
  logic [3:0]  v_idx [3][16];
  logic [11:0] v_dat [3][16];
  int          sd_n [3];
  int          sd_cyc [3][8];
  logic        sd_busy [3];
  int          err_cyc [3];
  logic        err_busy [3];
  logic        err_prev [3];

  initial begin
    for (int i = 0; i < 3; i++) err_prev[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (adc_start[i] === 1'b1) begin
          if (st_n[i] < 64) begin
            st_cyc[i][st_n[i]] = cyc;
            st_din[i][st_n[i]] = adc_din[i];
          end
          st_n[i]++;
        end
        if (adc_done[i] === 1'b1 && busy[i] === 1'b1) begin
          if (dn_n[i] < 64) dn_din[i][dn_n[i]] = adc_din[i];
          dn_n[i]++;
        end
        if (ch_valid[i] === 1'b1) begin
          if (v_n[i] < 16) begin
            v_cyc[i][v_n[i]] = cyc;
            v_idx[i][v_n[i]] = ch_idx[i];
            v_dat[i][v_n[i]] = ch_data[i];
          end
          v_n[i]++;
        end
        if (scan_done[i] === 1'b1) begin
          if (sd_n[i] < 8) sd_cyc[i][sd_n[i]] = cyc;
          sd_busy[i] = busy[i];
          sd_n[i]++;
        end
        if (err[i] === 1'b1 && err_prev[i] !== 1'b1) begin
          err_cyc[i]  = cyc;
          err_busy[i] = busy[i];
        end
        err_prev[i] = err[i];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clr(input int i);
    st_n[i]      = 0;
    dn_n[i]      = 0;
    v_n[i]       = 0;
    sd_n[i]      = 0;
    err_cyc[i]   = -1;
    drv_frame[i] = 0;
  endtask

  task automatic pulse(input int i, output int c);
    @(negedge clk);
    scan_en[i] = 1'b1;
    c = cyc;
    @(negedge clk);
    scan_en[i] = 1'b0;
  endtask

  task automatic wait_sd(input int i, input int target, input int budget);
    int k = 0;
    while (sd_n[i] < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (sd_n[i] < target) chk("wait_scan_done", sd_n[i], target);
  endtask

  task automatic wait_st(input int i, input int target, input int budget);
    int k = 0;
    while (st_n[i] < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (st_n[i] < target) chk("wait_start", st_n[i], target);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_din [3];
  int c0;
  int k;

  initial begin
    exp_din = '{8'h00, 8'h10, 8'hB0};
    rst_n   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      scan_en[i]  = 1'b0;
      drv_mute[i] = 1'b0;
      clr(i);
    end
    for (int f = 0; f < 64; f++) begin
      drv_val[0][f] = 12'(f);
      drv_val[1][f] = 12'h000;
      drv_val[2][f] = 12'hFFF;
    end
    drv_val[1][0] = 12'hFA0;
    drv_val[1][1] = 12'd100;
    drv_val[1][2] = 12'd101;
    drv_val[1][3] = 12'd102;
    drv_val[1][4] = 12'd104;

    repeat (3) @(negedge clk);
    chk("rst_adc_start", adc_start[0], 0);
    chk("rst_adc_din", adc_din[0], 0);
    chk("rst_outputs", {ch_data[0], ch_idx[0], ch_valid[0], scan_done[0], busy[0], err[0]}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two channels, no averaging, dout = frame number
    clr(0);
    pulse(0, c0);
    wait_sd(0, 1, 200);
    repeat (5) @(negedge clk);
    chk("t1_n_start", st_n[0], 3);
    for (int f = 0; f < 3; f++) begin
      chk("t1_din", st_din[0][f], exp_din[f]);
      chk("t1_din_hold", dn_din[0][f], exp_din[f]);
    end
    chk("t1_start_lat", st_cyc[0][0] - c0, 1);
    chk("t1_start_gap", st_cyc[0][1] - st_cyc[0][0], LAT + 1 + GAP0);
    chk("t1_start_gap_emit", st_cyc[0][2] - st_cyc[0][1], LAT + 2 + GAP0);
    chk("t1_n_valid", v_n[0], 2);
    chk("t1_v0", {v_idx[0][0], v_dat[0][0]}, {4'd0, 12'd1});
    chk("t1_v1", {v_idx[0][1], v_dat[0][1]}, {4'd1, 12'd2});
    chk("t1_v0_cyc", v_cyc[0][0] - st_cyc[0][1], LAT + 1);
    chk("t1_sd_cyc", sd_cyc[0][0] - st_cyc[0][2], LAT + 2 + GAP0);
    chk("t1_sd_busy", sd_busy[0], 0);
    chk("t1_n_sd", sd_n[0], 1);

    // One channel, 4-sample average: (100+101+102+104)>>2 = 101
    clr(1);
    pulse(1, c0);
    wait_sd(1, 1, 300);
    chk("t2_n_start", st_n[1], 5);
    chk("t2_din3", st_din[1][3], 8'h00);
    chk("t2_din4", st_din[1][4], 8'hB0);
    chk("t2_n_valid", v_n[1], 1);
    chk("t2_data", v_dat[1][0], 101);
    chk("t2_idx", v_idx[1][0], 0);

    // Full-scale average over 16 samples
    clr(2);
    pulse(2, c0);
    wait_sd(2, 1, 600);
    chk("t3_n_start", st_n[2], 17);
    chk("t3_n_valid", v_n[2], 1);
    chk("t3_data", v_dat[2][0], 12'hFFF);

    // Timeout with a silent driver
    drv_mute[0] = 1'b1;
    clr(0);
    pulse(0, c0);
    k = 0;
    while (err[0] !== 1'b1 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    chk("t4_err_cyc", err_cyc[0] - st_cyc[0][0], TO0 + 1);
    chk("t4_err_busy", err_busy[0], 0);
    repeat (5) @(negedge clk);
    chk("t4_no_valid", v_n[0], 0);
    chk("t4_no_sd", sd_n[0], 0);
    chk("t4_idle", busy[0], 0);
    chk("t4_err_sticky", err[0], 1);
    drv_mute[0] = 1'b0;
    clr(0);
    pulse(0, c0);
    chk("t4_err_clear", err[0], 0);
    wait_sd(0, 1, 200);
    chk("t4_rescan_valid", v_n[0], 2);

    // Held scan_en: back-to-back scans, then drop mid-scan
    repeat (3) @(negedge clk);
    clr(0);
    @(negedge clk);
    scan_en[0] = 1'b1;
    wait_sd(0, 1, 200);
    wait_st(0, 4, 100);
    scan_en[0] = 1'b0;
    wait_sd(0, 2, 200);
    repeat (40) @(negedge clk);
    chk("t5_n_sd", sd_n[0], 2);
    chk("t5_n_start", st_n[0], 6);
    chk("t5_turnaround", st_cyc[0][3] - sd_cyc[0][0], 2);
    chk("t5_n_valid", v_n[0], 4);
    chk("t5_idx_order", {v_idx[0][0], v_idx[0][1], v_idx[0][2], v_idx[0][3]}, 16'h0101);

    // Reset during WAIT of frame 3
    clr(1);
    pulse(1, c0);
    wait_st(1, 4, 200);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_start", adc_start[1], 0);
    chk("t6_rst_din", adc_din[1], 0);
    chk("t6_rst_data", ch_data[1], 0);
    chk("t6_rst_outs", {ch_idx[1], ch_valid[1], scan_done[1], busy[1], err[1]}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_stray_busy", busy[1], 0);
    chk("t6_stray_valid", v_n[1], 0);
    chk("t6_stray_start", st_n[1], 4);
    clr(1);
    pulse(1, c0);
    wait_sd(1, 1, 300);
    chk("t6_n_start", st_n[1], 5);
    chk("t6_din0", st_din[1][0], 8'h00);
    chk("t6_n_valid", v_n[1], 1);
    chk("t6_data", v_dat[1][0], 101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Multi-channel scan sequencer that sits directly upstream of the TLC2543 SPI driver. It issues one-shot conversion commands (`start`/`din`) across a configurable channel range and collects the driver's `dout`/`done` results. Because the TLC2543 is pipelined, each result belongs to the previous command, and the block re-aligns results to channels accordingly. It averages 2^AVG_LOG2 samples per channel and presents one averaged 12-bit word per channel to the memristor-array readout logic.

## Interface
- N_CH, 8: channels per scan, legal 1..11; channel addresses 0..N_CH-1.
- AVG_LOG2, 2: log2 samples per channel, legal 0..4.
- GAP, 20: idle clk cycles between `adc_done` and the next `adc_start`, legal ≥1.
- TIMEOUT, 2000: clk cycles allowed from `adc_start` to `adc_done` before abort.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- scan_en  in  1  level; high in IDLE starts a scan, and scanning repeats while it stays high.
- adc_start  out  1  one-cycle command pulse to the driver.
- adc_din  out  8  command byte, held stable from `adc_start` until `adc_done`.
- adc_dout  in  12  driver result, valid in the cycle `adc_done`=1.
- adc_done  in  1  one-cycle frame-complete pulse from the driver.
- ch_data  out  12  averaged channel result.
- ch_idx  out  4  channel number of `ch_data`.
- ch_valid  out  1  one-cycle strobe qualifying `ch_data`/`ch_idx`.
- scan_done  out  1  one-cycle pulse after the last channel of a scan.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky timeout flag; cleared by reset or by the next scan start.

## Operation
- Command byte: {addr[3:0], 2'b00, 1'b0, 1'b0}, meaning 12-bit length, MSB-first, unipolar. The dummy address is 4'hB, the (Vref+ − Vref−)/2 self-test.
- Frames per scan: F = N_CH·2^AVG_LOG2 + 1.
  - Frame k (k = 0..F−2) addresses channel floor(k / 2^AVG_LOG2).
  - Frame F−1 addresses 4'hB.
- Result alignment:
  - The result returned in frame 0 is discarded.
  - The result returned in frame k ≥ 1 belongs to frame k−1's channel.
- Accumulator: width 12+AVG_LOG2, unsigned. It is cleared at the first sample of each channel and adds `adc_dout` at each aligned `adc_done`.
- After a channel's 2^AVG_LOG2-th sample:
  - `ch_data` = acc[11+AVG_LOG2 : AVG_LOG2], truncating the fraction, no rounding.
  - `ch_idx` = that channel.
  - `ch_valid` = 1.
- States:
  - IDLE: on `scan_en`=1, go to ISSUE. Frame counter is cleared and `err` is cleared.
  - ISSUE: one cycle. `adc_start`=1 and `adc_din` is driven, then go to WAIT.
  - WAIT: on `adc_done`, capture and accumulate, then go to EMIT if a channel completed, otherwise GAP. If the timeout counter reaches TIMEOUT, set `err` and go to IDLE; no `ch_valid` or `scan_done` is issued.
  - EMIT: one cycle. `ch_valid`=1, then go to GAP.
  - GAP: count GAP cycles. Then go to ISSUE if frames remain. Otherwise `scan_done`=1 for one cycle and go to IDLE.
- `scan_en` falling mid-scan does not abort; the current scan completes. A new scan starts only from IDLE.
- `adc_done` outside WAIT is ignored.
- Reset values: `adc_start`=0, `adc_din`=8'h00, `ch_data`=0, `ch_idx`=0, `ch_valid`=0, `scan_done`=0, `busy`=0, `err`=0. The state is IDLE, and all counters and the accumulator are 0.
- Reset mid-scan returns everything to the reset values on the next clk edge. The driver's in-flight frame completes on its own, and its `adc_done` is ignored.

## Timing
- `adc_start` is asserted in the cycle after IDLE sees `scan_en`=1 (1-cycle latency).
- `adc_din` changes only in the ISSUE cycle and is stable through WAIT.
- `adc_done` at cycle t:
  - `ch_valid` is at t+1 if a channel completed.
  - The next `adc_start` is at t+1+GAP, or t+2+GAP when EMIT is inserted.
- `scan_done` is asserted in the cycle after the final GAP expires, and `busy` drops in the same cycle.
- If `scan_en` is still high, the next scan's `adc_start` follows 2 cycles after `scan_done`.
- The timeout counter starts at ISSUE. `err` sets in the cycle after the count reaches TIMEOUT.
- `ch_valid` for channel c always precedes `ch_valid` for channel c+1. Exactly N_CH strobes occur per completed scan.

## Test plan
- N_CH=2, AVG_LOG2=0; driver model returns dout=frame number 0,1,2 → `adc_din` sequence 8'h00, 8'h10, 8'hB0. Then `ch_valid` with (idx 0, data 1) and (idx 1, data 2), then one `scan_done`.
- N_CH=1, AVG_LOG2=2; aligned samples 100, 101, 102, 104 → single `ch_valid` with `ch_data`=101 (407>>2); 5 frames total.
- All samples 12'hFFF, AVG_LOG2=4 → `ch_data`=12'hFFF, with no accumulator overflow.
- Driver never pulses `adc_done` → `err`=1 exactly TIMEOUT+1 cycles after `adc_start`. The block returns to IDLE with no `ch_valid`. The next scan start clears `err`.
- `scan_en` held high for 2 scans; `scan_en` pulse dropped mid-scan → back-to-back scans run with a 2-cycle turnaround. The dropped-pulse scan completes, and no further scan starts after it.
- `rst_n` low for 1 cycle during WAIT of frame 3 → all outputs are at their reset values on the next cycle. A stray `adc_done` is ignored, and a fresh scan starts cleanly from frame 0.
